// File: rtl/fa32_share_arb.sv
// fa32_share_arb: two requesters share one 32-bit add/subtract unit.
// A round-robin grant in IDLE accepts one operation and registers its
// operands. EXEC runs the shared adder for one cycle. RESP holds the
// captured result and flags until the consumer takes them.

// One-bit full adder cell used to build the ripple chain.
module FullAdderBit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// Ripple-carry add/subtract unit with status flags.
// ctrl=0 computes a+b, ctrl=1 computes a+~b+1. For subtraction the carry
// out is inverted so cf reads as a borrow (1 when a < b unsigned).
module FA_32bits #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ctrl,
  output logic [W-1:0] s,
  output logic         of,
  output logic         cf,
  output logic         zf,
  output logic         sf,
  output logic         pf
);
  logic [W-1:0] b_eff;
  logic [W:0]   carry;

  assign b_eff    = b ^ {W{ctrl}};
  assign carry[0] = ctrl;

  for (genvar i = 0; i < W; i++) begin : g_bit
    FullAdderBit u_bit (
      .a   (a[i]),
      .b   (b_eff[i]),
      .cin (carry[i]),
      .s   (s[i]),
      .cout(carry[i+1])
    );
  end

  // Signed overflow is the carry into the sign bit differing from the carry out.
  assign of = carry[W] ^ carry[W-1];
  assign cf = carry[W] ^ ctrl;
  assign zf = (s == '0);
  assign sf = s[W-1];
  assign pf = ~^s[7:0];
endmodule

module fa32_share_arb #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic         req0_ctrl,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic         req1_ctrl,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [W-1:0] resp_s,
  output logic         resp_of,
  output logic         resp_cf,
  output logic         resp_zf,
  output logic         resp_sf,
  output logic         resp_pf
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state;
  state_t       next_state;

  // rr=0 favours requester 0, rr=1 favours requester 1 on contention.
  logic         rr;
  logic         grant_valid;
  logic         grant_id;
  logic         accept;

  logic         op_ctrl;
  logic         op_id;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;

  logic [W-1:0] sum;
  logic         sum_of;
  logic         sum_cf;
  logic         sum_zf;
  logic         sum_sf;
  logic         sum_pf;

  FA_32bits #(.W(W)) u_adder (
    .a   (op_a),
    .b   (op_b),
    .ctrl(op_ctrl),
    .s   (sum),
    .of  (sum_of),
    .cf  (sum_cf),
    .zf  (sum_zf),
    .sf  (sum_sf),
    .pf  (sum_pf)
  );

  // Round-robin grant: a lone requester wins, contention goes to the rr favourite.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = rr;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Next-state and handshake decode; readys are only offered in IDLE.
  always_comb begin
    next_state = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = grant_valid && (grant_id == 1'b0);
        req1_ready = grant_valid && (grant_id == 1'b1);
        if (grant_valid) begin
          accept     = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC: begin
        next_state = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Latch the granted operation and hand priority to the other port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr      <= 1'b0;
      op_ctrl <= 1'b0;
      op_id   <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
    end else if (accept) begin
      rr      <= ~grant_id;
      op_id   <= grant_id;
      op_ctrl <= grant_id ? req1_ctrl : req0_ctrl;
      op_a    <= grant_id ? req1_a    : req0_a;
      op_b    <= grant_id ? req1_b    : req0_b;
    end
  end

  // Capture adder result and flags at the end of EXEC; they hold through RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_id <= 1'b0;
      resp_s  <= '0;
      resp_of <= 1'b0;
      resp_cf <= 1'b0;
      resp_zf <= 1'b0;
      resp_sf <= 1'b0;
      resp_pf <= 1'b0;
    end else if (state == EXEC) begin
      resp_id <= op_id;
      resp_s  <= sum;
      resp_of <= sum_of;
      resp_cf <= sum_cf;
      resp_zf <= sum_zf;
      resp_sf <= sum_sf;
      resp_pf <= sum_pf;
    end
  end

  assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_fa32_share_arb.sv
// Directed self-checking bench for fa32_share_arb.
// Inputs change and outputs are sampled 1ns after the falling edge, so
// every observation sits half a period away from the active rising edge.
module tb_fa32_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_ctrl;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_ctrl;
  logic [31:0] req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_s;
  logic        resp_of, resp_cf, resp_zf, resp_sf, resp_pf;
  logic [4:0]  flags;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        port;
    logic        ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic [4:0]  fl;
  } vec_t;

  fa32_share_arb #(.W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_ctrl (req0_ctrl),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_ctrl (req1_ctrl),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id   (resp_id),
    .resp_s    (resp_s),
    .resp_of   (resp_of),
    .resp_cf   (resp_cf),
    .resp_zf   (resp_zf),
    .resp_sf   (resp_sf),
    .resp_pf   (resp_pf)
  );

  // Flags packed as {of, cf, zf, sf, pf} for compact comparison.
  assign flags = {resp_of, resp_cf, resp_zf, resp_sf, resp_pf};

  // 10ns free-running clock.
  always #5 clk = ~clk;

  // Raise one requester's valid, wait (bounded) for its ready, let the accept
  // edge pass, then drop valid. Called and returns at a sample point; on return
  // the DUT is in EXEC.
  task automatic applyStimulus(input logic port, input logic ctrl,
                               input logic [31:0] a, input logic [31:0] b);
    bit seen;
    seen = 1'b0;
    if (port == 1'b0) begin
      req0_ctrl = ctrl; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end else begin
      req1_ctrl = ctrl; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end
    #1;
    for (int i = 0; i < 20; i++) begin
      if ((port == 1'b0 && req0_ready) || (port == 1'b1 && req1_ready)) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    if (!seen) begin
      total++; bad++;
      $display("[TB] FAIL accept_timeout: port %0d never got ready, required ready=1", port);
    end
    @(posedge clk);
    @(negedge clk); #1;
    if (port == 1'b0) req0_valid = 1'b0;
    else              req1_valid = 1'b0;
  endtask

  // Reset values, then a ready in the very first post-reset cycle.
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    total++; if (resp_s !== 32'h0) begin bad++; $display("[TB] FAIL reset_resp_s: got %h expected 00000000", resp_s); end
    total++; if (flags !== 5'b0) begin bad++; $display("[TB] FAIL reset_flags: got %b expected 00000", flags); end
    total++; if (resp_id !== 1'b0) begin bad++; $display("[TB] FAIL reset_resp_id: got %b expected 0", resp_id); end
    total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("[TB] FAIL reset_readys: got %b expected 00", {req0_ready, req1_ready}); end
    // 1 + 0xFFFFFFFF wraps to zero with carry out.
    req1_ctrl = 1'b0; req1_a = 32'h0000_0001; req1_b = 32'hFFFF_FFFF; req1_valid = 1'b1;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("[TB] FAIL first_cycle_ready: got %b expected 01", {req0_ready, req1_ready}); end
    @(posedge clk);
    @(negedge clk); #1;
    req1_valid = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL wrap_exec_valid: got %b expected 0", resp_valid); end
    @(negedge clk); #1;
    total++; if ({resp_valid, resp_id, resp_s, flags} !== {1'b1, 1'b1, 32'h0, 5'b01101})
      begin bad++; $display("[TB] FAIL wrap_resp: got v=%b id=%b s=%h fl=%b expected v=1 id=1 s=00000000 fl=01101", resp_valid, resp_id, resp_s, flags); end
    @(negedge clk); #1;
  endtask

  // Single-port arithmetic with latency check: result appears exactly two cycles after accept.
  task automatic test_arith();
    vec_t vecs[4];
    vecs[0] = '{1'b0, 1'b0, 32'h4BDE5515, 32'hD7451D52, 32'h23237267, 5'b01000};
    vecs[1] = '{1'b1, 1'b1, 32'h4BDE5515, 32'hD7451D52, 32'h749937C3, 5'b01001};
    vecs[2] = '{1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b10011};
    vecs[3] = '{1'b1, 1'b1, 32'h00000005, 32'h00000005, 32'h00000000, 5'b00101};
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(vecs[k].port, vecs[k].ctrl, vecs[k].a, vecs[k].b);
      total++; if (resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL arith%0d_exec_valid: got %b expected 0", k, resp_valid); end
      @(negedge clk); #1;
      total++; if (resp_valid !== 1'b1) begin bad++; $display("[TB] FAIL arith%0d_latency: resp_valid got %b expected 1", k, resp_valid); end
      total++; if (resp_s !== vecs[k].s) begin bad++; $display("[TB] FAIL arith%0d_s: got %h expected %h", k, resp_s, vecs[k].s); end
      total++; if (flags !== vecs[k].fl) begin bad++; $display("[TB] FAIL arith%0d_flags: got %b expected %b (of cf zf sf pf)", k, flags, vecs[k].fl); end
      total++; if (resp_id !== vecs[k].port) begin bad++; $display("[TB] FAIL arith%0d_id: got %b expected %b", k, resp_id, vecs[k].port); end
      @(negedge clk); #1;
      total++; if (resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL arith%0d_consumed: resp_valid got %b expected 0", k, resp_valid); end
    end
  endtask

  // Both ports valid continuously: grants alternate starting with port 0
  // (last grant before this was port 1).
  task automatic test_contention();
    logic        got_id[6];
    logic [31:0] got_s[6];
    int resps, accepts, r0, r1, both;
    resps = 0; accepts = 0; r0 = 0; r1 = 0; both = 0;
    resp_ready = 1'b1;
    req0_ctrl = 1'b0; req0_a = 32'h100; req0_b = 32'h1; req0_valid = 1'b1;
    req1_ctrl = 1'b1; req1_a = 32'h100; req1_b = 32'h1; req1_valid = 1'b1;
    #1;
    for (int cyc = 0; cyc < 60 && resps < 6; cyc++) begin
      if (req0_ready && req1_ready) both++;
      if (req0_ready) r0++;
      if (req1_ready) r1++;
      if (req0_ready || req1_ready) accepts++;
      if (resp_valid) begin
        got_id[resps] = resp_id;
        got_s[resps]  = resp_s;
        resps++;
      end
      @(negedge clk);
      if (accepts >= 6) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    total++; if (resps !== 6) begin bad++; $display("[TB] FAIL contention_count: got %0d responses expected 6", resps); end
    for (int i = 0; i < resps; i++) begin
      total++; if (got_id[i] !== i[0]) begin bad++; $display("[TB] FAIL contention_id%0d: got %b expected %b", i, got_id[i], i[0]); end
      total++; if (got_s[i] !== (i[0] ? 32'h000000FF : 32'h00000101))
        begin bad++; $display("[TB] FAIL contention_s%0d: got %h expected %h", i, got_s[i], (i[0] ? 32'h000000FF : 32'h00000101)); end
    end
    total++; if ({r0, r1} !== {32'd3, 32'd3}) begin bad++; $display("[TB] FAIL contention_ready_pulses: got r0=%0d r1=%0d expected 3 and 3", r0, r1); end
    total++; if (both !== 0) begin bad++; $display("[TB] FAIL contention_double_grant: got %0d cycles expected 0", both); end
  endtask

  // Hold off the consumer for 10 cycles while port 1 waits, then release.
  task automatic test_backpressure();
    resp_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h12345678, 32'h11111111);
    req1_ctrl = 1'b1; req1_a = 32'd10; req1_b = 32'd3; req1_valid = 1'b1;
    @(negedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({resp_valid, resp_id, resp_s, flags, req0_ready, req1_ready} !==
          {1'b1, 1'b0, 32'h23456789, 5'b00000, 1'b0, 1'b0}) begin
        bad++;
        $display("[TB] FAIL backpressure_hold%0d: got v=%b id=%b s=%h fl=%b rdy=%b%b expected v=1 id=0 s=23456789 fl=00000 rdy=00",
                 i, resp_valid, resp_id, resp_s, flags, req0_ready, req1_ready);
      end
      @(negedge clk); #1;
    end
    resp_ready = 1'b1;
    @(negedge clk); #1;
    total++; if ({resp_valid, req0_ready, req1_ready} !== 3'b001)
      begin bad++; $display("[TB] FAIL backpressure_release: got v=%b rdy=%b%b expected v=0 rdy=01", resp_valid, req0_ready, req1_ready); end
    @(posedge clk);
    @(negedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk); #1;
    total++; if ({resp_valid, resp_id, resp_s, flags} !== {1'b1, 1'b1, 32'd7, 5'b00000})
      begin bad++; $display("[TB] FAIL backpressure_next: got v=%b id=%b s=%h fl=%b expected v=1 id=1 s=00000007 fl=00000", resp_valid, resp_id, resp_s, flags); end
    @(negedge clk); #1;
  endtask

  // Reset in EXEC and in RESP discards the op; rr returns to favouring port 0.
  task automatic test_reset_mid_op();
    int leaked;
    leaked = 0;
    resp_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd1, 32'd2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_exec_valid: got %b expected 0", resp_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (resp_valid !== 1'b0) leaked++;
    end
    total++; if (leaked !== 0) begin bad++; $display("[TB] FAIL rst_exec_no_resp: got %0d valid cycles expected 0", leaked); end
    applyStimulus(1'b0, 1'b0, 32'd3, 32'd4);
    @(negedge clk); #1;
    total++; if (resp_valid !== 1'b1) begin bad++; $display("[TB] FAIL rst_resp_reached: got %b expected 1", resp_valid); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    total++; if ({resp_valid, resp_id, resp_s, flags} !== {1'b0, 1'b0, 32'h0, 5'b00000})
      begin bad++; $display("[TB] FAIL rst_resp_clear: got v=%b id=%b s=%h fl=%b expected all zero", resp_valid, resp_id, resp_s, flags); end
    // Last grant before reset was port 0; only a cleared rr gives port 0 again.
    req0_ctrl = 1'b0; req0_a = 32'd6; req0_b = 32'd7; req0_valid = 1'b1;
    req1_ctrl = 1'b1; req1_a = 32'd9; req1_b = 32'd4; req1_valid = 1'b1;
    resp_ready = 1'b1;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("[TB] FAIL rst_first_grant: got rdy=%b%b expected 10", req0_ready, req1_ready); end
    @(posedge clk);
    @(negedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk); #1;
    total++; if ({resp_valid, resp_id, resp_s} !== {1'b1, 1'b0, 32'd13})
      begin bad++; $display("[TB] FAIL rst_post_op0: got v=%b id=%b s=%h expected v=1 id=0 s=0000000d", resp_valid, resp_id, resp_s); end
    @(negedge clk); #1;
    total++; if (req1_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_waiting_port1: ready got %b expected 1", req1_ready); end
    @(posedge clk);
    @(negedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk); #1;
    total++; if ({resp_valid, resp_id, resp_s} !== {1'b1, 1'b1, 32'd5})
      begin bad++; $display("[TB] FAIL rst_post_op1: got v=%b id=%b s=%h expected v=1 id=1 s=00000005", resp_valid, resp_id, resp_s); end
    @(negedge clk); #1;
  endtask

  // Run every scenario in order, then report.
  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_ctrl = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_ctrl = 1'b0; req1_a = '0; req1_b = '0;
    resp_ready = 1'b1;
    test_reset();
    test_arith();
    test_contention();
    test_backpressure();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
